seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle accumulator ALU with add/sub/logic ops, bit-serial
// shifts and an optional shift-add multiplier.
// Optional feature: define SEQ_ALU_MUL_EN to build the multiplier; without
// it opcode 9 behaves like any other reserved opcode.
module seq_alu #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W)
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         op_err,
  output logic [W-1:0] result,
  output logic [7:0]   flags
);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

  // flag byte: sign, zero, aux, parity(even), carry; bits 1/3/5 stay 0
  function automatic logic [7:0] mk_flags(input logic [W-1:0] v, input logic c, input logic ac);
    return {v[W-1], (v == '0), 1'b0, ac, 1'b0, ~^v, 1'b0, c};
  endfunction

  state_t        state;
  logic [CW:0]   cnt;
  logic [W-1:0]  sh_val;
  logic          sh_left;

  logic          cin;
  logic [W:0]    add_s, sub_d;
  logic [4:0]    add_n, sub_n;
  logic [CW-1:0] n_cnt;
  logic          shift_go, mul_go;
  logic [W-1:0]  alu_res, sh_next;
  logic [7:0]    alu_flags;
  logic          alu_err, sh_out;

  // ADC consumes the carry as it stood before the accept edge
  assign cin   = (op == 4'd1) ? flags[0] : 1'b0;
  assign add_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign add_n = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
  assign sub_d = {1'b0, a} - {1'b0, b};
  assign sub_n = {1'b0, a[3:0]} - {1'b0, b[3:0]};

  assign n_cnt    = b[CW-1:0];
  assign shift_go = ((op == 4'd7) || (op == 4'd8)) && (n_cnt != '0);

  assign sh_next = sh_left ? {sh_val[W-2:0], 1'b0} : {1'b0, sh_val[W-1:1]};
  assign sh_out  = sh_left ? sh_val[W-1] : sh_val[0];

`ifdef SEQ_ALU_MUL_EN
  logic [W-1:0]   mcand;
  logic [2*W-1:0] prod, prod_next;
  logic [W:0]     hsum;

  assign mul_go = (op == 4'd9);
  // one shift-add step: conditionally add multiplicand into the high half, shift right
  assign hsum      = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
  assign prod_next = {hsum, prod[W-1:1]};
`else
  assign mul_go = 1'b0;
`endif

  // single-cycle outcome for the op presented at the inputs
  always_comb begin
    alu_res   = result;
    alu_flags = flags;
    alu_err   = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        alu_res   = add_s[W-1:0];
        alu_flags = mk_flags(add_s[W-1:0], add_s[W], add_n[4]);
      end
      4'd2: begin
        alu_res   = sub_d[W-1:0];
        alu_flags = mk_flags(sub_d[W-1:0], sub_d[W], sub_n[4]);
      end
      4'd3:       alu_flags = mk_flags(sub_d[W-1:0], sub_d[W], sub_n[4]);
      4'd4: begin
        alu_res   = a & b;
        alu_flags = mk_flags(a & b, 1'b0, 1'b0);
      end
      4'd5: begin
        alu_res   = a | b;
        alu_flags = mk_flags(a | b, 1'b0, 1'b0);
      end
      4'd6: begin
        alu_res   = a ^ b;
        alu_flags = mk_flags(a ^ b, 1'b0, 1'b0);
      end
      4'd7, 4'd8: begin
        // zero-count shift: nothing shifted out, so carry is 0
        alu_res   = a;
        alu_flags = mk_flags(a, 1'b0, 1'b0);
      end
      default:    alu_err = 1'b1;
    endcase
  end

  // control FSM with registered status outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      sh_val  <= '0;
      sh_left <= 1'b0;
      result  <= '0;
      flags   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      op_err  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand   <= '0;
      prod    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (shift_go) begin
            sh_val  <= a;
            sh_left <= (op == 4'd7);
            cnt     <= {1'b0, n_cnt};
            state   <= SHIFT;
          end else if (mul_go) begin
`ifdef SEQ_ALU_MUL_EN
            mcand <= a;
            prod  <= {{W{1'b0}}, b};
`endif
            cnt   <= (CW+1)'(W);
            state <= MUL;
          end else begin
            result <= alu_res;
            flags  <= alu_flags;
            op_err <= alu_err;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        SHIFT: begin
          sh_val <= sh_next;
          cnt    <= cnt - 1'b1;
          if (cnt == (CW+1)'(1)) begin
            result <= sh_next;
            flags  <= mk_flags(sh_next, sh_out, 1'b0);
            done   <= 1'b1;
            state  <= DONE;
          end
        end
`ifdef SEQ_ALU_MUL_EN
        MUL: begin
          prod <= prod_next;
          cnt  <= cnt - 1'b1;
          if (cnt == (CW+1)'(1)) begin
            result <= prod_next[W-1:0];
            flags  <= mk_flags(prod_next[W-1:0], |prod_next[2*W-1:W], 1'b0);
            done   <= 1'b1;
            state  <= DONE;
          end
        end
`endif
        DONE: begin
          busy   <= 1'b0;
          done   <= 1'b0;
          op_err <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
